echo_qualify_fifo: RTL and testbench

- Downstream of the per-shot rise/fall extraction stage. Consumes one {rise, fall} timestamp pair per laser shot, qualifies it and computes pulse width and offset-corrected time-of-flight.
- Tags each shot with an angle index derived from the motor zero mark.
- Buffers result words in a small FIFO with a valid/ready interface to the packet assembler.

---
 rtl/echo_qualify_fifo_pkg.sv | 38 +++
 rtl/echo_qualify_fifo_sync_fifo_fwft.sv | 61 ++++++
 rtl/echo_qualify_fifo.sv | 162 ++++++++++++++++
 tb/tb_echo_qualify_fifo.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/echo_qualify_fifo_pkg.sv
// Shared definitions for the echo qualification block and the packet assembler.
// Holds the status codes and the packet field layout, so that both ends of the
// result FIFO decode a word the same way.
//   Packet word, MSB to LSB: {angle, status[1:0], tof, width}
package echo_qualify_fifo_pkg;

  localparam int STATUS_W = 2;

  typedef enum logic [STATUS_W-1:0] {
    ST_OK     = 2'd0,
    ST_NOECHO = 2'd1,
    ST_WIDTH  = 2'd2,
    ST_RANGE  = 2'd3
  } status_e;

  // Field offsets are functions of the data width so that a non-default
  // DATA_W still decodes correctly on the assembler side.
  function automatic int pkt_width_lsb();
    return 0;
  endfunction

  function automatic int pkt_tof_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int pkt_status_lsb(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int pkt_angle_lsb(input int data_w);
    return 2 * data_w + STATUS_W;
  endfunction

  function automatic int pkt_w(input int data_w, input int angle_w);
    return angle_w + STATUS_W + 2 * data_w;
  endfunction

endpackage

// File: rtl/echo_qualify_fifo_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
// rd_data always shows the head word (zero while empty). A read is a pop of
// the head and is ignored when empty; a write while full is accepted only
// when a pop happens in the same cycle. No write-to-read bypass.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   wr_en, wr_data      write request and data
//   rd_en, rd_data      pop request and head word
//   full, empty, count  occupancy status (count is 0..DEPTH)
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  // Gating keeps the output at zero after reset without resetting the array.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/echo_qualify_fifo.sv
// Per-shot echo qualification with angle tagging and a result FIFO.
// Takes one {rise, fall} pair per laser shot, computes width and
// offset-corrected time of flight, classifies the shot, tags it with the
// angle index counted from the motor zero mark and queues the result word.
// Ports:
//   i_clk, i_rst_n                     clock, async active-low reset
//   i_rise_data, i_fall_data           shot timestamps (0 = no echo)
//   i_data_valid                       one-cycle shot strobe
//   i_zero_sign                        motor zero-mark level
//   i_tdc_offset, i_width_min/max      quasi-static configuration
//   o_pkt_data, o_pkt_valid, i_pkt_ready   FWFT result stream
//   o_overflow, o_drop_cnt             drop reporting
module echo_qualify_fifo
  import echo_qualify_fifo_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ANGLE_W    = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int RANGE_MAX  = 2000
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [DATA_W-1:0]                 i_rise_data,
  input  logic [DATA_W-1:0]                 i_fall_data,
  input  logic                              i_data_valid,
  input  logic                              i_zero_sign,
  input  logic [DATA_W-1:0]                 i_tdc_offset,
  input  logic [DATA_W-1:0]                 i_width_min,
  input  logic [DATA_W-1:0]                 i_width_max,
  output logic [ANGLE_W+2+2*DATA_W-1:0]     o_pkt_data,
  output logic                              o_pkt_valid,
  input  logic                              i_pkt_ready,
  output logic                              o_overflow,
  output logic [15:0]                       o_drop_cnt
);

  localparam int PKT_W = pkt_w(DATA_W, ANGLE_W);

  // Zero-mark edge and angle counter
  logic               zero_q;
  logic               zero_edge;
  logic [ANGLE_W-1:0] angle_cnt;

  assign zero_edge = i_zero_sign & ~zero_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      zero_q    <= 1'b0;
      angle_cnt <= '0;
    end else begin
      zero_q <= i_zero_sign;
      // A strobe coinciding with the edge takes angle 0, so the counter lands on 1.
      if (zero_edge)
        angle_cnt <= i_data_valid ? ANGLE_W'(1) : '0;
      else if (i_data_valid && (angle_cnt != '1))
        angle_cnt <= angle_cnt + 1'b1;
    end
  end

  // Stage 1: capture the shot and the comparisons that do not need config
  logic               s1_valid;
  logic [DATA_W-1:0]  s1_rise;
  logic [DATA_W-1:0]  s1_fall;
  logic [ANGLE_W-1:0] s1_angle;
  logic               s1_noecho;
  logic               s1_range;
  logic               s1_fall_gt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid   <= 1'b0;
      s1_rise    <= '0;
      s1_fall    <= '0;
      s1_angle   <= '0;
      s1_noecho  <= 1'b0;
      s1_range   <= 1'b0;
      s1_fall_gt <= 1'b0;
    end else begin
      s1_valid <= i_data_valid;
      if (i_data_valid) begin
        s1_rise    <= i_rise_data;
        s1_fall    <= i_fall_data;
        s1_angle   <= zero_edge ? '0 : angle_cnt;
        s1_noecho  <= (i_rise_data == '0);
        s1_range   <= (i_rise_data > DATA_W'(RANGE_MAX));
        s1_fall_gt <= (i_fall_data > i_rise_data);
      end
    end
  end

  // Stage 2: field computation, config sampled here
  logic [DATA_W-1:0] width_c;
  logic [DATA_W-1:0] tof_c;
  status_e           status_c;

  always_comb begin
    width_c  = s1_fall_gt ? (s1_fall - s1_rise) : '0;
    tof_c    = (s1_rise > i_tdc_offset) ? (s1_rise - i_tdc_offset) : '0;
    status_c = ST_OK;
    if (s1_noecho) begin
      status_c = ST_NOECHO;
      width_c  = '0;
      tof_c    = '0;
    end else if (s1_range) begin
      status_c = ST_RANGE;
    end else if (!s1_fall_gt || (width_c < i_width_min) || (width_c > i_width_max)) begin
      status_c = ST_WIDTH;
    end
  end

  logic             s2_valid;
  logic [PKT_W-1:0] s2_word;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_word  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_word <= {s1_angle, status_c, tof_c, width_c};
    end
  end

  // Result FIFO and drop accounting
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        pop;
  logic                        drop;

  assign pop         = i_pkt_ready & ~fifo_empty;
  assign drop        = s2_valid & fifo_full & ~pop;
  assign o_pkt_valid = (fifo_count != '0);

  sync_fifo_fwft #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .wr_en   (s2_valid),
    .wr_data (s2_word),
    .rd_en   (i_pkt_ready),
    .rd_data (o_pkt_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      if (drop && (o_drop_cnt != 16'hFFFF)) o_drop_cnt <= o_drop_cnt + 16'd1;
      // A drop in the same cycle as the zero edge keeps the flag set.
      if (drop)           o_overflow <= 1'b1;
      else if (zero_edge) o_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_echo_qualify_fifo.sv
module tb_echo_qualify_fifo;

  logic        clk;
  logic        rst_n;
  logic [15:0] rise_data;
  logic [15:0] fall_data;
  logic        data_valid;
  logic        zero_sign;
  logic [15:0] tdc_offset;
  logic [15:0] width_min;
  logic [15:0] width_max;
  logic [45:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic        overflow;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [45:0] exp_q[$];

  echo_qualify_fifo dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rise_data  (rise_data),
    .i_fall_data  (fall_data),
    .i_data_valid (data_valid),
    .i_zero_sign  (zero_sign),
    .i_tdc_offset (tdc_offset),
    .i_width_min  (width_min),
    .i_width_max  (width_max),
    .o_pkt_data   (pkt_data),
    .o_pkt_valid  (pkt_valid),
    .i_pkt_ready  (pkt_ready),
    .o_overflow   (overflow),
    .o_drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Monitor: every accepted head word is compared against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && pkt_valid && pkt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got=%h", pkt_data);
      end else begin
        logic [45:0] e;
        e = exp_q.pop_front();
        if (pkt_data !== e) begin
          errors++;
          $display("FAIL word got=%h (ang=%0d st=%0d tof=%0d w=%0d) exp=%h (ang=%0d st=%0d tof=%0d w=%0d)",
                   pkt_data, pkt_data[45:34], pkt_data[33:32], pkt_data[31:16], pkt_data[15:0],
                   e, e[45:34], e[33:32], e[31:16], e[15:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic shot(input logic [15:0] r, input logic [15:0] f, input logic [11:0] ang,
                      input logic [1:0] st, input logic [15:0] tof, input logic [15:0] w,
                      input bit push);
    rise_data  = r;
    fall_data  = f;
    data_valid = 1'b1;
    if (push) exp_q.push_back({ang, st, tof, w});
    tick();
    data_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout got=%0d words_left exp=0", name, exp_q.size());
    end
    repeat (4) tick();
    chk({name, "_empty_after"}, 64'(pkt_valid), 64'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    rise_data  = '0;
    fall_data  = '0;
    data_valid = 1'b0;
    zero_sign  = 1'b0;
    tdc_offset = 16'd20;
    width_min  = 16'd10;
    width_max  = 16'd100;
    pkt_ready  = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 64'(pkt_valid), 0);
    chk("rst_data", 64'(pkt_data), 0);
    chk("rst_drop", 64'(drop_cnt), 0);
    chk("rst_ovf", 64'(overflow), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic shot and latency
    shot(16'd100, 16'd140, 12'd0, 2'd0, 16'd80, 16'd40, 1);
    chk("lat_c1", 64'(pkt_valid), 0);
    tick();
    chk("lat_c2", 64'(pkt_valid), 0);
    tick();
    chk("lat_c3", 64'(pkt_valid), 1);
    drain("basic");

    // Back-to-back qualification vectors
    shot(16'd0,    16'd0,    12'd1, 2'd1, 16'd0,    16'd0,   1);
    shot(16'd2500, 16'd2600, 12'd2, 2'd3, 16'd2480, 16'd100, 1);
    shot(16'd50,   16'd40,   12'd3, 2'd2, 16'd30,   16'd0,   1);
    shot(16'd10,   16'd30,   12'd4, 2'd0, 16'd0,    16'd20,  1);
    shot(16'd100,  16'd300,  12'd5, 2'd2, 16'd80,   16'd200, 1);
    shot(16'd100,  16'd105,  12'd6, 2'd2, 16'd80,   16'd5,   1);
    shot(16'd100,  16'd110,  12'd7, 2'd0, 16'd80,   16'd10,  1);
    shot(16'd2000, 16'd2050, 12'd8, 2'd0, 16'd1980, 16'd50,  1);
    shot(16'd2001, 16'd2050, 12'd9, 2'd3, 16'd1981, 16'd49,  1);
    shot(16'd0,    16'd30,   12'd10, 2'd1, 16'd0,   16'd0,   1);
    drain("qual");

    // Re-zero the angle counter, then overflow burst
    zero_sign = 1'b1;
    tick();
    zero_sign = 1'b0;
    tick();
    pkt_ready = 1'b0;
    for (int i = 0; i < 20; i++)
      shot(16'd100, 16'd140, 12'(i), 2'd0, 16'd80, 16'd40, i < 16);
    repeat (4) tick();
    chk("burst_drop", 64'(drop_cnt), 4);
    chk("burst_ovf", 64'(overflow), 1);
    chk("burst_valid", 64'(pkt_valid), 1);
    pkt_ready = 1'b1;
    drain("burst");
    chk("burst_ovf_sticky", 64'(overflow), 1);

    // Five more shots, then a zero edge coincident with a strobe
    for (int i = 0; i < 5; i++)
      shot(16'd100, 16'd140, 12'(20 + i), 2'd0, 16'd80, 16'd40, 1);
    chk("pre_zero_ovf", 64'(overflow), 1);
    zero_sign = 1'b1;
    shot(16'd100, 16'd140, 12'd0, 2'd0, 16'd80, 16'd40, 1);
    shot(16'd100, 16'd140, 12'd1, 2'd0, 16'd80, 16'd40, 1);
    zero_sign = 1'b0;
    chk("zero_ovf_clr", 64'(overflow), 0);
    drain("zero");
    chk("zero_drop_kept", 64'(drop_cnt), 4);

    // Full FIFO: write coinciding with a pop is kept, next write is dropped
    pkt_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      shot(16'd100, 16'd140, 12'(2 + i), 2'd0, 16'd80, 16'd40, 1);
    repeat (4) tick();
    chk("full_nodrop", 64'(drop_cnt), 4);
    shot(16'd100, 16'd140, 12'd18, 2'd0, 16'd80, 16'd40, 1);
    tick();
    pkt_ready = 1'b1;
    tick();
    pkt_ready = 1'b0;
    chk("full_pop_write_drop", 64'(drop_cnt), 4);
    shot(16'd100, 16'd140, 12'd19, 2'd0, 16'd80, 16'd40, 0);
    repeat (3) tick();
    chk("full_still16_drop", 64'(drop_cnt), 5);
    chk("full_ovf", 64'(overflow), 1);
    pkt_ready = 1'b1;
    drain("full");

    // Async reset in the middle of a burst
    pkt_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      shot(16'd100, 16'd140, 12'd0, 2'd0, 16'd80, 16'd40, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(pkt_valid), 0);
    chk("mid_rst_drop", 64'(drop_cnt), 0);
    chk("mid_rst_ovf", 64'(overflow), 0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_valid", 64'(pkt_valid), 0);
    pkt_ready = 1'b1;
    tdc_offset = 16'd30;
    shot(16'd100, 16'd140, 12'd0, 2'd0, 16'd70, 16'd40, 1);
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
